// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared constants for the SDRAM burst arbiter.
//   - FSM state encodings for sdram_arbiter (also visible on its debug port)
//   - Read/write direction encoding driven on o_sdram_rw
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT_WR = 3'd2;
    localparam logic [2:0] WAIT_RD = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/sdram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter
// Grant decision between one write requester and one read requester.
// The grant is combinational; only the round-robin pointer is registered.
//   CLK, RST  : clock, asynchronous active-high reset
//   wrReq     : write burst requested
//   wrUrgent  : write side is urgent (only meaningful together with wrReq)
//   rdReq     : read burst requested
//   advance   : the current grant is being taken this cycle
//   grantWr   : write side would be granted
//   grantRd   : read side would be granted
// Priority: urgent write, then alternate when both ask, else the sole asker.
// -----------------------------------------------------------------------------
module sdram_rr_arbiter (
    input  logic CLK,
    input  logic RST,
    input  logic wrReq,
    input  logic wrUrgent,
    input  logic rdReq,
    input  logic advance,
    output logic grantWr,
    output logic grantRd
);

    // Remembers which side took the previous grant. Resetting it to "read"
    // makes the first contested grant go to the write side.
    logic lastWasRead;

    always_comb begin
        grantWr = 1'b0;
        grantRd = 1'b0;
        if (wrReq && wrUrgent) begin
            grantWr = 1'b1;
        end else if (wrReq && rdReq) begin
            grantWr = lastWasRead;
            grantRd = !lastWasRead;
        end else begin
            grantWr = wrReq;
            grantRd = rdReq;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lastWasRead <= 1'b1;
        end else if (advance) begin
            lastWasRead <= grantRd;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Arbitrates write and read burst requests onto a single SDRAM controller port.
// Each granted request becomes one burst of BurstLength words.
//
// Ports
//   CLK, RST                       clock, asynchronous active-high reset
//   i_wr_req/i_wr_urgent/i_wr_addr write burst request, urgency, start address
//   i_wr_data, o_wr_pop            FWFT write word and its pop strobe
//   i_rd_req, i_rd_addr            read burst request, start address
//   o_wr_ack, o_rd_ack             one-cycle grant pulses
//   o_rd_data, o_rd_valid          read word, registered (1 cycle latency)
//   o_sdram_enable/rw/addr/data    command to the SDRAM controller (rw 1 = read)
//   i_sdram_busy                   controller cannot accept a command
//   i_sdram_valid_wr/valid_rd      controller consumed / produced a beat
//   i_sdram_data                   read word from the controller
//   o_busy                         FSM is not IDLE
//   o_error                        sticky timeout flag
//   o_dbg_state                    current FSM state (sdram_pkg encodings)
//
// Handshake: a request is level-held until the matching ack pulse is seen in
// the same cycle; the grant is taken on the rising edge that ends that cycle.
// A request still high after its ack simply asks for the next burst.
// Beats are one-cycle strobes from the controller and are only honoured while
// waiting on a burst of the matching direction.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int AddressWidth  = 24,
    parameter int WordLength    = 16,
    parameter int BurstLength   = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_wr_req,
    input  logic                    i_wr_urgent,
    input  logic [AddressWidth-1:0] i_wr_addr,
    input  logic [WordLength-1:0]   i_wr_data,
    output logic                    o_wr_pop,
    input  logic                    i_rd_req,
    input  logic [AddressWidth-1:0] i_rd_addr,
    output logic                    o_wr_ack,
    output logic                    o_rd_ack,
    output logic [WordLength-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_sdram_enable,
    output logic                    o_sdram_rw,
    output logic [AddressWidth-1:0] o_sdram_addr,
    output logic [WordLength-1:0]   o_sdram_data,
    input  logic                    i_sdram_busy,
    input  logic                    i_sdram_valid_wr,
    input  logic                    i_sdram_valid_rd,
    input  logic [WordLength-1:0]   i_sdram_data,
    output logic                    o_busy,
    output logic                    o_error,
    output logic [2:0]              o_dbg_state
);

    localparam int BeatW = $clog2(BurstLength + 1);
    localparam int TimeW = $clog2(TimeoutCycles + 1);

    logic [2:0]              state;
    logic [BeatW-1:0]        beatCnt;
    logic [TimeW-1:0]        cycleCnt;
    logic                    rwReg;
    logic [AddressWidth-1:0] addrReg;
    logic                    errorReg;
    logic [WordLength-1:0]   rdDataReg;
    logic                    rdValidReg;

    logic grantWr;
    logic grantRd;
    logic startBurst;
    logic beatWr;
    logic beatRd;
    logic lastBeat;
    logic inBurst;
    logic timeUp;

    assign startBurst = (state == IDLE) && !i_sdram_busy && (grantWr || grantRd);

    sdram_rr_arbiter u_rr (
        .CLK      (CLK),
        .RST      (RST),
        .wrReq    (i_wr_req),
        .wrUrgent (i_wr_urgent),
        .rdReq    (i_rd_req),
        .advance  (startBurst),
        .grantWr  (grantWr),
        .grantRd  (grantRd)
    );

    // Beats only count in the waiting state of the matching direction.
    assign beatWr   = (state == WAIT_WR) && i_sdram_valid_wr;
    assign beatRd   = (state == WAIT_RD) && i_sdram_valid_rd;
    assign lastBeat = (beatWr || beatRd) && (beatCnt == BeatW'(BurstLength - 1));
    assign inBurst  = (state == ISSUE) || (state == WAIT_WR) || (state == WAIT_RD);
    // cycleCnt is 0 during the ISSUE cycle, so the edge that would bring it to
    // TimeoutCycles is the TimeoutCycles-th edge after issue.
    assign timeUp   = inBurst && (cycleCnt == TimeW'(TimeoutCycles - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            beatCnt  <= '0;
            cycleCnt <= '0;
            rwReg    <= WRITE;
            addrReg  <= '0;
            errorReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startBurst) begin
                        state    <= ISSUE;
                        beatCnt  <= '0;
                        cycleCnt <= '0;
                        rwReg    <= grantRd ? READ : WRITE;
                        addrReg  <= grantRd ? i_rd_addr : i_wr_addr;
                    end
                end
                ISSUE: begin
                    cycleCnt <= cycleCnt + 1'b1;
                    if (timeUp) begin
                        state    <= RECOVER;
                        errorReg <= 1'b1;
                    end else begin
                        state <= (rwReg == READ) ? WAIT_RD : WAIT_WR;
                    end
                end
                WAIT_WR, WAIT_RD: begin
                    cycleCnt <= cycleCnt + 1'b1;
                    if (beatWr || beatRd) begin
                        beatCnt <= beatCnt + 1'b1;
                    end
                    // A final beat landing on the timeout edge still completes.
                    if (lastBeat) begin
                        state <= IDLE;
                    end else if (timeUp) begin
                        state    <= RECOVER;
                        errorReg <= 1'b1;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdValidReg <= 1'b0;
            rdDataReg  <= '0;
        end else begin
            rdValidReg <= beatRd;
            if (beatRd) begin
                rdDataReg <= i_sdram_data;
            end
        end
    end

    // Acks are combinational from IDLE, so they are also masked by RST to keep
    // every output low while reset is asserted.
    assign o_wr_ack       = startBurst && grantWr && !RST;
    assign o_rd_ack       = startBurst && grantRd && !RST;
    assign o_wr_pop       = beatWr;
    assign o_sdram_data   = (state == WAIT_WR) ? i_wr_data : '0;
    assign o_sdram_enable = (state == ISSUE);
    assign o_sdram_rw     = rwReg;
    assign o_sdram_addr   = addrReg;
    assign o_rd_data      = rdDataReg;
    assign o_rd_valid     = rdValidReg;
    assign o_busy         = (state != IDLE);
    assign o_error        = errorReg;
    assign o_dbg_state    = state;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter AddressWidth, default 24, meaning SDRAM word address width (bank+row+col).
REQ-002 SHALL have parameter WordLength, default 16, meaning SDRAM data word width.
REQ-003 SHALL have parameter BurstLength, default 8, meaning words per transaction.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, meaning maximum CLK cycles from issue to last beat.
REQ-005 SHALL have port CLK  input  1  meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST  input  1  meaning reset, asynchronous, active-high.
REQ-007 SHALL have ports i_wr_req  input  1, i_wr_urgent  input  1, i_wr_addr  input  AddressWidth, meaning write-burst request, urgency flag (upstream FIFO near full) and start address.
REQ-008 SHALL have ports i_wr_data  input  WordLength, o_wr_pop  output  1, meaning write word from a FWFT source and its pop strobe.
REQ-009 SHALL have ports i_rd_req  input  1, i_rd_addr  input  AddressWidth, meaning read-burst request and start address.
REQ-010 SHALL have ports o_wr_ack, o_rd_ack  output  1 each, meaning one-cycle grant pulse; o_rd_data  output  WordLength; o_rd_valid  output  1.
REQ-011 SHALL have ports o_sdram_enable  output  1, o_sdram_rw  output  1 (1 = read), o_sdram_addr  output  AddressWidth, o_sdram_data  output  WordLength.
REQ-012 SHALL have ports i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd  input  1 each, i_sdram_data  input  WordLength.
REQ-013 SHALL have ports o_busy  output  1 (not IDLE), o_error  output  1 (sticky timeout flag).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_WR, WAIT_RD, RECOVER.
- IDLE->ISSUE: any request present and i_sdram_busy=0; grant latched, ack pulsed the same cycle.
- ISSUE: o_sdram_enable=1 for exactly one cycle with latched addr/rw; then ->WAIT_WR or WAIT_RD.
- WAIT_*: count beats; after beat BurstLength ->IDLE.
- Timeout: ->RECOVER; one cycle later ->IDLE.
REQ-015 SHALL arbitrate: i_wr_urgent&i_wr_req wins; else if both requested, grant the side not granted last (round-robin); else the sole requester.
REQ-016 SHALL initialise round-robin pointer so the first contested grant goes to write.
REQ-017 SHALL, in WAIT_WR, drive o_sdram_data=i_wr_data and pulse o_wr_pop in each cycle i_sdram_valid_wr=1.
REQ-018 SHALL, in WAIT_RD, register i_sdram_data to o_rd_data with o_rd_valid one cycle after each i_sdram_valid_rd (latency 1).
REQ-019 SHALL ignore i_sdram_valid_wr outside WAIT_WR and i_sdram_valid_rd outside WAIT_RD (no pop, no valid).
REQ-020 SHALL use a $clog2(BurstLength+1)-bit beat counter, cleared on entering ISSUE; ->IDLE when counter reaches BurstLength, never wraps.
REQ-021 SHALL count cycles from ISSUE; reaching TimeoutCycles sets o_error (held until reset) and enters RECOVER, abandoning remaining beats.
REQ-022 SHALL hold requests not acknowledged; requester drops request after ack or re-requests for the next burst; a request held through ack in IDLE issues a new burst.
REQ-023 SHALL not enter ISSUE while i_sdram_busy=1; stays IDLE with no ack.

Reset
REQ-024 SHALL, on RST=1, asynchronously force IDLE and all outputs to 0 (o_sdram_addr/data, o_rd_data zero), counters 0, round-robin to write-first, o_error=0.
REQ-025 SHALL, on RST mid-burst, abandon the burst; no pop or valid after reset release until a new grant.

Structure
REQ-026 SHALL place state encodings and the rw constants (READ=1, WRITE=0) in shared package sdram_pkg.
REQ-027 SHALL factor the grant decision into sub-module sdram_rr_arbiter (combinational grant, registered pointer).

Verification
REQ-028 Write only: i_wr_req, addr 0x000100, 8 valid_wr beats -> 1 ack, 1 enable with rw=0, 8 pops, back to IDLE.
REQ-029 Contested: both requests held, no urgency -> grant order W,R,W,R over 4 bursts.
REQ-030 Urgent: read granted last time, both req plus i_wr_urgent -> write granted again.
REQ-031 Read latency: valid_rd with data 0xA5A5 -> o_rd_valid/o_rd_data=0xA5A5 exactly one cycle later, 8 valids total.
REQ-032 Timeout: TimeoutCycles=32, 3 beats then silence -> o_error=1 at cycle 32, RECOVER, IDLE, next request served.
REQ-033 Reset mid-burst after 4 beats -> outputs 0 immediately, stray valid_wr causes no pop.
